// File: rtl/spi_slave_pkg.sv
// Shared SPI constants: slave and master state encodings plus synchronizer depth.
package spi_slave_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } slave_state_t;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_LOAD = 2'd1,
    M_XFER = 2'd2,
    M_DONE = 2'd3
  } master_state_t;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall detection
// against a history flop; RESET_VAL matches the line's idle level.
module sync_edge
  import spi_slave_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_hist;
  logic                   w_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= {SYNC_STAGES{RESET_VAL}};
      r_hist  <= RESET_VAL;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
      r_hist  <= r_chain[SYNC_STAGES-1];
    end
  end

  assign w_sync = r_chain[SYNC_STAGES-1];
  assign o_rise = w_sync & ~r_hist;
  assign o_fall = ~w_sync & r_hist;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, oversampled by clk: full-duplex word shifting with
// back-to-back words, abort on early deselect and a registered miso.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int BIT_CNT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  new_data,
  output logic                  busy,
  output logic                  abort
);

  logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;
  logic w_mosi_sync, w_last, w_complete;

  logic [SYNC_STAGES-1:0]   r_mosi_chain;
  slave_state_t             r_state;
  logic [DATA_WIDTH-1:0]    r_tx;
  logic [DATA_WIDTH-1:0]    r_rx;
  logic [DATA_WIDTH-1:0]    r_data_out;
  logic [BIT_CNT_WIDTH-1:0] r_cnt;
  logic                     r_miso;
  logic                     r_new_data;
  logic                     r_abort;

  sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_async(sck),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_async(ss_n),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  // mosi only needs the same delay as sck so the sampled bit lines up with the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mosi_chain <= '0;
    else     r_mosi_chain <= {r_mosi_chain[SYNC_STAGES-2:0], mosi};
  end

  assign w_mosi_sync = r_mosi_chain[SYNC_STAGES-1];
  assign w_last      = (r_cnt == {BIT_CNT_WIDTH{1'b1}});
  assign w_complete  = w_sck_rise & w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tx       <= '0;
      r_rx       <= '0;
      r_data_out <= '0;
      r_cnt      <= '0;
      r_miso     <= 1'b0;
      r_new_data <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_new_data <= 1'b0;
      r_abort    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_miso <= 1'b0;
          if (w_ss_fall) begin
            r_state <= ST_SHIFT;
            r_tx    <= data_in;
            r_rx    <= '0;
            r_cnt   <= '0;
            r_miso  <= data_in[DATA_WIDTH-1];
          end
        end
        ST_SHIFT: begin
          if (w_sck_rise) begin
            r_rx  <= {r_rx[DATA_WIDTH-2:0], w_mosi_sync};
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_data_out <= {r_rx[DATA_WIDTH-2:0], w_mosi_sync};
              r_new_data <= 1'b1;
              r_tx       <= data_in;
            end
          end else if (w_sck_fall) begin
            // a fall with the counter at zero follows a reload: present the new MSB unshifted
            if (r_cnt == '0) begin
              r_miso <= r_tx[DATA_WIDTH-1];
            end else begin
              r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
              r_miso <= r_tx[DATA_WIDTH-2];
            end
          end
          if (w_ss_rise) begin
            r_state <= ST_IDLE;
            r_miso  <= 1'b0;
            if ((r_cnt != '0) && !w_complete) r_abort <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign miso     = r_miso;
  assign data_out = r_data_out;
  assign new_data = r_new_data;
  assign abort    = r_abort;
  assign busy     = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: an SPI master model drives directed and
// random words; a monitor pops expected new_data/abort events and compares.
module tb_spi_slave;

  localparam int DW   = 16;
  localparam int HALF = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          sck;
  logic          ss_n;
  logic          mosi;
  logic [DW-1:0] data_in;
  logic          miso;
  logic [DW-1:0] data_out;
  logic          new_data;
  logic          busy;
  logic          abort;

  typedef struct {
    bit            is_abort;
    logic [DW-1:0] word;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           mon_ev;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] last_word = '0;

  spi_slave #(.DATA_WIDTH(DW), .BIT_CNT_WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .miso    (miso),
    .data_in (data_in),
    .data_out(data_out),
    .new_data(new_data),
    .busy    (busy),
    .abort   (abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every new_data or abort pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && (new_data || abort)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: new_data=%b abort=%b data_out=%h", new_data, abort, data_out);
      end else begin
        mon_ev = exp_q.pop_front();
        check("event_kind", {30'd0, new_data, abort}, mon_ev.is_abort ? 32'd1 : 32'd2);
        check("event_data_out", {16'd0, data_out}, {16'd0, mon_ev.word});
        $display("event %s data_out=%h expected=%h", mon_ev.is_abort ? "abort" : "new_data",
                 data_out, mon_ev.word);
      end
    end
  end

  // One master word: mosi set while sck low, miso sampled just before each rise
  task automatic spi_word(input logic [DW-1:0] m, input int nbits, input logic [DW-1:0] next_din,
                          input bit ss_with_last, output logic [DW-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = m[DW-1-i];
      if (i == 8) data_in = next_din;
      #(HALF);
      got = {got[DW-2:0], miso};
      sck = 1'b1;
      if (ss_with_last && i == nbits - 1) ss_n = 1'b1;
      if (i == 4) check("busy_mid_word", {31'd0, busy}, 32'd1);
      #(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [DW-1:0] m, input logic [DW-1:0] din, input bit same_edge);
    logic [DW-1:0] got;
    data_in = din;
    exp_q.push_back('{is_abort: 1'b0, word: m});
    last_word = m;
    #(HALF);
    ss_n = 1'b0;
    #(HALF);
    spi_word(m, DW, din, same_edge, got);
    if (!same_edge) begin
      #(HALF);
      ss_n = 1'b1;
    end
    #(2 * HALF);
    $display("xfer mosi=%h data_in=%h master_got=%h", m, din, got);
    check("master_rx", {16'd0, got}, {16'd0, din});
    check("idle_busy_miso", {30'd0, busy, miso}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] got0, got1, m, d;
    int            phase;
    rst = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0; data_in = '0;
    #25 rst = 1'b0;
    #20;
    check("reset_outputs", {13'd0, busy, miso, new_data, abort, data_out}, 32'd0);

    // basic word, both directions
    xfer(16'h5555, 16'hF0F0, 1'b0);

    // back-to-back words with ss_n held low
    data_in = 16'hA1A1;
    exp_q.push_back('{is_abort: 1'b0, word: 16'h1234});
    exp_q.push_back('{is_abort: 1'b0, word: 16'hABCD});
    #(HALF); ss_n = 1'b0; #(HALF);
    spi_word(16'h1234, DW, 16'h5A5A, 1'b0, got0);
    spi_word(16'hABCD, DW, 16'h5A5A, 1'b0, got1);
    #(HALF); ss_n = 1'b1; #(2 * HALF);
    last_word = 16'hABCD;
    $display("xfer b2b got0=%h got1=%h", got0, got1);
    check("b2b_master_rx0", {16'd0, got0}, 32'h0000A1A1);
    check("b2b_master_rx1", {16'd0, got1}, 32'h00005A5A);
    check("b2b_data_out", {16'd0, data_out}, 32'h0000ABCD);

    // early deselect after 7 bits
    data_in = 16'h0F0F;
    exp_q.push_back('{is_abort: 1'b1, word: last_word});
    #(HALF); ss_n = 1'b0; #(HALF);
    spi_word(16'hFFFF, 7, 16'h0F0F, 1'b0, got0);
    #(HALF); ss_n = 1'b1; #(2 * HALF);
    $display("xfer abort after 7 bits data_out=%h", data_out);
    check("abort_data_out_kept", {16'd0, data_out}, {16'd0, last_word});
    check("abort_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of a word
    data_in = 16'hC3C3;
    #(HALF); ss_n = 1'b0; #(HALF);
    spi_word(16'hAAAA, 5, 16'hC3C3, 1'b0, got0);
    #7 rst = 1'b1; ss_n = 1'b1;
    #30;
    check("rst_mid_outputs", {13'd0, busy, miso, new_data, abort, data_out}, 32'd0);
    rst = 1'b0;
    last_word = '0;
    #(HALF);
    check("rst_release_idle", {31'd0, busy}, 32'd0);
    xfer(16'h00FF, 16'h3C3C, 1'b0);

    // sck activity while deselected
    for (int i = 0; i < 10; i++) begin
      sck = 1'b1; #(HALF);
      check("spurious_hi", {30'd0, busy, miso}, 32'd0);
      sck = 1'b0; #(HALF);
      check("spurious_lo", {30'd0, busy, miso}, 32'd0);
    end
    check("spurious_data_out", {16'd0, data_out}, {16'd0, last_word});

    // completion and deselect seen in the same clk: completion wins
    xfer(16'h8001, 16'h7E7E, 1'b1);
    check("same_edge_data_out", {16'd0, data_out}, 32'h00008001);

    // random data with random sck/clk phase
    for (int k = 0; k < 100; k++) begin
      phase = $urandom_range(0, 9);
      #(phase);
      m = DW'($urandom);
      d = DW'($urandom);
      xfer(m, d, 1'b0);
    end

    #(4 * HALF);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
